// File: rtl/bram_block_streamer_pkg.sv
// bram_stream_pkg: shared block type, FSM states and default sizes for the BRAM block streamer
package bram_stream_pkg;
    localparam int DEF_REGISTER_SIZE = 32;
    localparam int DEF_NUM_BLOCKS    = 128;
    localparam int DEF_READ_LATENCY  = 2;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int BLOCK_CNT_W       = $clog2(DEF_NUM_BLOCKS + 1);

    typedef logic [DEF_REGISTER_SIZE-1:0] block_t;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} streamer_state_t;
endpackage

// File: rtl/bram_block_streamer_if.sv
// bram_block_streamer_if: store read port plus the outgoing valid/ready block stream
interface bram_block_streamer_if #(parameter int REGISTER_SIZE = 32);
    logic                     read_next_block_out;
    logic [REGISTER_SIZE-1:0] read_block_in;
    logic                     read_block_valid_in;
    logic [REGISTER_SIZE-1:0] data_out;
    logic                     data_valid_out;
    logic                     data_ready_in;
    logic                     data_last_out;

    modport master (
        output read_next_block_out, data_out, data_valid_out, data_last_out,
        input  read_block_in, read_block_valid_in, data_ready_in
    );
    modport slave (
        input  read_next_block_out, data_out, data_valid_out, data_last_out,
        output read_block_in, read_block_valid_in, data_ready_in
    );
endinterface

// File: rtl/bram_block_streamer_fifo.sv
// block_skid_fifo: small synchronous FIFO with occupancy count; head reads as 0 when empty
module block_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push_in,
    input  logic                       pop_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // pointer and count update; a push into a full FIFO is only taken when the head leaves the same cycle
    always_comb begin
        do_pop  = pop_in && count_q != '0;
        do_push = push_in && (count_q != CW'(DEPTH) || do_pop);
        wr_d    = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d    = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // storage array, no reset needed since the head is masked while empty
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= data_in;
    end

    // pointer and occupancy registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign data_out  = count_q != '0 ? mem_q[rd_q] : '0;
    assign count_out = count_q;
endmodule

// File: rtl/bram_block_streamer.sv
// bram_block_streamer: issues NUM_BLOCKS store reads per start and streams the blocks LSB-first.
// Optional sticky protocol error output is enabled with BRAM_STREAMER_ERR_EN.
module bram_block_streamer
    import bram_stream_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int NUM_BLOCKS    = DEF_NUM_BLOCKS,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  done_out,
`ifdef BRAM_STREAMER_ERR_EN
    output logic                  error_out,
`endif
    bram_block_streamer_if.master bus
);
    localparam int CW = $clog2(NUM_BLOCKS + 1);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_depth_check
        $error("FIFO_DEPTH too small to sustain one block per cycle");
    end

    streamer_state_t state_q, state_d;
    logic [CW-1:0]   issued_q, issued_d, accepted_q, accepted_d;
    logic [OW-1:0]   inflight_q, inflight_d, occupancy;
    logic            issue, pop, valid, full;

    assign valid = occupancy != '0;
    assign full  = occupancy == OW'(FIFO_DEPTH);
    assign pop   = valid && bus.data_ready_in;
    // credits: every block already read or in flight owns a FIFO slot, so pushes never overflow
    assign issue = state_q == STREAM && int'(issued_q) < NUM_BLOCKS
                   && int'(occupancy) + int'(inflight_q) < FIFO_DEPTH;

    assign bus.read_next_block_out = issue;
    assign bus.data_valid_out      = valid;
    assign bus.data_last_out       = valid && accepted_q == CW'(NUM_BLOCKS - 1);
    assign busy_out                = state_q != IDLE;
    assign done_out                = state_q == DONE;

    block_skid_fifo #(.WIDTH(REGISTER_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_in  (bus.read_block_valid_in),
        .pop_in   (pop),
        .data_in  (bus.read_block_in),
        .data_out (bus.data_out),
        .count_out(occupancy)
    );

    // next state and counters; DONE is entered on the final handshake so done lands the next cycle
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q + CW'(issue);
        accepted_d = accepted_q + CW'(pop);
        inflight_d = inflight_q + OW'(issue)
                     - OW'(bus.read_block_valid_in && inflight_q != '0);
        case (state_q)
            IDLE: if (start_in) begin
                state_d    = STREAM;
                issued_d   = '0;
                accepted_d = '0;
            end
            STREAM: if (pop && accepted_q == CW'(NUM_BLOCKS - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef BRAM_STREAMER_ERR_EN
    logic error_q, error_d;

    // sticky error: unexpected store data, start while busy, or push into a full FIFO
    always_comb begin
        error_d = error_q
                  || (bus.read_block_valid_in && inflight_q == '0)
                  || (start_in && busy_out)
                  || (bus.read_block_valid_in && full && !pop);
    end

    // error flag register, cleared only by reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) error_q <= 1'b0;
        else         error_q <= error_d;
    end

    assign error_out = error_q;
`endif
endmodule

// File: tb/tb_bram_block_streamer.sv
// tb_bram_block_streamer: directed checks of the block streamer against a 2-cycle-latency store model
module tb_bram_block_streamer;
    localparam int NB = 8;

    logic clk, rst_n, start, spur;
    logic busy, done;
`ifdef BRAM_STREAMER_ERR_EN
    logic err;
`endif

    bram_block_streamer_if #(.REGISTER_SIZE(32)) bus ();

    bram_block_streamer #(.REGISTER_SIZE(32), .NUM_BLOCKS(NB), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .start_in(start),
        .busy_out(busy),
        .done_out(done),
`ifdef BRAM_STREAMER_ERR_EN
        .error_out(err),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // store model: address advances on each read pulse, data returns two cycles later
    logic        p1_v, p2_v;
    logic [31:0] p1_d, p2_d;
    logic [2:0]  addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_d <= '0;
            p2_d <= '0;
            addr <= '0;
        end else begin
            p1_v <= bus.read_next_block_out;
            p1_d <= 32'(addr) * 32'h1111_1111;
            addr <= addr + 3'(bus.read_next_block_out);
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end
    assign bus.read_block_valid_in = p2_v | spur;
    assign bus.read_block_in       = p2_d;

    int          checks = 0, failures = 0;
    int          cyc = 0, first_valid, done_cyc, hs_first, hs_last, pulses, popped, credit_viol, s;
    logic [31:0] got[$];
    logic [31:0] last_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_run();
        got.delete();
        first_valid = -1;
        done_cyc    = -1;
        hs_first    = -1;
        hs_last     = -1;
        pulses      = 0;
        popped      = 0;
        credit_viol = 0;
        last_mask   = '0;
    endtask

    // drive inputs on the falling edge, then record what the next rising edge will see
    task automatic step(input logic rdy, input logic st);
        @(negedge clk);
        bus.data_ready_in = rdy;
        start = st;
        #1;
        cyc++;
        if (bus.read_next_block_out) begin
            pulses++;
            if (pulses > popped + 4) credit_viol++;
        end
        if (bus.data_valid_out && first_valid < 0) first_valid = cyc;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (bus.data_valid_out && bus.data_ready_in) begin
            if (bus.data_last_out && got.size() < 32) last_mask[got.size()] = 1'b1;
            got.push_back(bus.data_out);
            popped++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
    endtask

    task automatic check_blocks(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(NB));
        for (int i = 0; i < NB; i++)
            chk($sformatf("%s_blk%0d", tag, i), 64'(i < got.size() ? got[i] : 32'hxxxx_xxxx),
                64'(32'(i) * 32'h1111_1111));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        spur  = 1'b0;
        bus.data_ready_in = 1'b1;
        clear_run();
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_read", 64'(bus.read_next_block_out), 64'd0);
        chk("rst_valid", 64'(bus.data_valid_out), 64'd0);
        chk("rst_last", 64'(bus.data_last_out), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // run 1: ready always high, gapless stream
        clear_run();
        s = cyc + 1;
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b1, 1'b0);
        chk("r1_first_valid", 64'(first_valid), 64'(s + 4));
        chk("r1_done_cyc", 64'(done_cyc), 64'(s + 12));
        chk("r1_gapless", 64'(hs_last - hs_first), 64'd7);
        chk("r1_last_mask", 64'(last_mask), 64'h80);
        chk("r1_pulses", 64'(pulses), 64'd8);
        chk("r1_credit", 64'(credit_viol), 64'd0);
        check_blocks("r1");
        step(1'b1, 1'b0);
        chk("r1_idle_busy", 64'(busy), 64'd0);

        // run 2: ready toggling every cycle
        clear_run();
        step(1'b1, 1'b1);
        for (int i = 0; i < 60 && done_cyc < 0; i++) step(i[0], 1'b0);
        chk("r2_done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("r2_pulses", 64'(pulses), 64'd8);
        chk("r2_credit", 64'(credit_viol), 64'd0);
        check_blocks("r2");

        // run 3: ready held low, reads stop once credits run out
        clear_run();
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("r3_pulses_stalled", 64'(pulses), 64'd4);
        chk("r3_occupancy", 64'(u_dut.occupancy), 64'd4);
        chk("r3_valid_held", 64'(bus.data_valid_out), 64'd1);
        chk("r3_head_block0", 64'(bus.data_out), 64'd0);
        chk("r3_read_low", 64'(bus.read_next_block_out), 64'd0);
        for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b1, 1'b0);
        chk("r3_done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("r3_pulses", 64'(pulses), 64'd8);
        check_blocks("r3");

        // run 4: mid-run start ignored, then back-to-back restart right after done
        clear_run();
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b1, i == 3);
        chk("r4a_pulses", 64'(pulses), 64'd8);
        check_blocks("r4a");
        clear_run();
        s = cyc + 1;
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b1, 1'b0);
        chk("r4b_done_cyc", 64'(done_cyc), 64'(s + 12));
        check_blocks("r4b");

        // run 5: asynchronous reset after three blocks, then a clean run
        clear_run();
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && got.size() < 3; i++) step(1'b1, 1'b0);
        chk("r5_three_accepted", 64'(got.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("r5_rst_busy", 64'(busy), 64'd0);
        chk("r5_rst_valid", 64'(bus.data_valid_out), 64'd0);
        chk("r5_rst_read", 64'(bus.read_next_block_out), 64'd0);
        chk("r5_rst_data", 64'(bus.data_out), 64'd0);
        chk("r5_rst_last", 64'(bus.data_last_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_run();
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b1, 1'b0);
        chk("r5_done_seen", 64'(done_cyc >= 0), 64'd1);
        check_blocks("r5");

`ifdef BRAM_STREAMER_ERR_EN
        step(1'b1, 1'b0);
        chk("err_clean", 64'(err), 64'd0);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("err_set", 64'(err), 64'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("err_reset", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_block_streamer.md
Name: bram_block_streamer

Overview:
- Downstream read sequencer for the block-addressed big-number BRAM store (REGISTER_SIZE-bit blocks, NUM_BLOCKS per number).
- On start, issues exactly NUM_BLOCKS read-advance pulses to the store and absorbs its fixed 2-cycle read latency in a small credit-controlled FIFO.
- Presents the blocks LSB-block first as a valid/ready stream with a last flag, for the modular arithmetic stages.

Parameters:
- REGISTER_SIZE, 32, block width in bits
- NUM_BLOCKS, 128, blocks per number; the store's read address wraps to 0 after exactly this many advances
- READ_LATENCY, 2, cycles from read pulse to store valid
- FIFO_DEPTH, 4, skid FIFO entries; must be >= READ_LATENCY+2 for 1 block/cycle

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-low reset
- start_in  input  1  pulse: stream one full number
- busy_out  output  1  high from accepted start until done
- done_out  output  1  one-cycle pulse after last block handshake
- read_next_block_out  output  1  advance/read pulse to store
- read_block_in  input  REGISTER_SIZE  store read data
- read_block_valid_in  input  1  store read-data valid (pipe2)
- data_out  output  REGISTER_SIZE  stream data (FIFO head)
- data_valid_out  output  1  stream valid
- data_ready_in  input  1  stream ready
- data_last_out  output  1  high with block NUM_BLOCKS-1

Behaviour:
- Reset (rst_in low, async): state IDLE; all counters 0; FIFO empty; busy_out, done_out, read_next_block_out, data_valid_out, data_last_out = 0; data_out = 0.
- FSM IDLE -> STREAM on start_in. STREAM -> DONE when accepted_cnt reaches NUM_BLOCKS. DONE -> IDLE unconditionally after 1 cycle; done_out = 1 in DONE only.
- start_in while not IDLE: ignored, no side effect.
- Counters: issued_cnt, accepted_cnt, width clog2(NUM_BLOCKS+1); inflight_cnt and occupancy, width clog2(FIFO_DEPTH+1).
- read_next_block_out (combinational from registered state): STREAM && issued_cnt < NUM_BLOCKS && occupancy + inflight_cnt < FIFO_DEPTH.
- inflight_cnt: +1 on issue, -1 on read_block_valid_in; both together leaves it unchanged.
- FIFO push on read_block_valid_in. Pop on data_valid_out && data_ready_in. Simultaneous push and pop are legal when full or empty; there is no bypass, so a push is visible the next cycle.
- Credit rule guarantees no overflow. Block data is never dropped or duplicated under any ready pattern.
- data_last_out = data_valid_out && accepted_cnt == NUM_BLOCKS-1.
- Latency:
  - start_in sampled in cycle t; first read pulse in t+1; first data_valid_out in t+4.
  - With ready held high, the stream is gapless: 1 block/cycle, done_out in t+NUM_BLOCKS+4.
- Store alignment: exactly NUM_BLOCKS advances per run, so the store address returns to 0 and back-to-back runs stay aligned.
- Reset mid-run aborts all state. The store must be reset in the same window, otherwise its address is misaligned; this is not detected without the optional feature.
- data_ready_in low stalls output only. Reads continue until credits are exhausted, then read_next_block_out stays low.

Optional Feature:
- Macro: BRAM_STREAMER_ERR_EN.
- With the macro:
  - Adds output error_out (1 bit, sticky, cleared only by reset).
  - Sets on read_block_valid_in while inflight_cnt == 0.
  - Sets on start_in while busy_out is high.
  - Sets on push into a full FIFO.
- Without the macro: no error_out port, no checking logic; behaviour is otherwise identical.

Decomposition:
- Package bram_stream_pkg:
  - block_t typedef (logic [REGISTER_SIZE-1:0])
  - streamer_state_t enum {IDLE, STREAM, DONE}
  - localparam BLOCK_CNT_W = clog2(NUM_BLOCKS+1)
- Sub-module block_skid_fifo:
  - Parameters: width, depth.
  - Synchronous FIFO with push, pop, head data, occupancy count, same async active-low reset.

Test Plan:
- NUM_BLOCKS=8; store model returns addr*0x11111111; start_in pulse, ready always high -> blocks 0x0..0x77777777 in order; data_valid_out first at t+4; gapless for 8 cycles; data_last_out on 8th; done_out at t+12.
- Same config, ready toggling 1-0 every cycle -> all 8 blocks in order; read pulses never exceed occupancy+inflight < 4; exactly 8 read pulses total.
- Ready held low 20 cycles after start -> exactly 4 read pulses, occupancy 4, valid held with block 0. Release ready -> remaining 4 blocks, done_out.
- Two back-to-back runs, second start_in the cycle after done_out -> second run again returns block 0 first (store address wrapped). A start_in pulse mid-run is ignored.
- rst_in low for 1 cycle while 3 blocks are accepted -> all outputs 0 immediately (async); new start after reset delivers block 0 first.
- With BRAM_STREAMER_ERR_EN: inject a spurious read_block_valid_in in IDLE -> error_out goes 1 and stays 1 until reset.
